// File: rtl/mos_pkg.sv
// Shared types and constants for the 6502 interrupt-entry sequencer.
package mos_pkg;

  localparam int unsigned VEC_W = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RESET_HOLD,
    ST_DUMMY1,
    ST_DUMMY2,
    ST_PUSH_PCH,
    ST_PUSH_PCL,
    ST_PUSH_P,
    ST_VEC_LO,
    ST_VEC_HI
  } seq_state_e;

  typedef enum logic [1:0] {
    SRC_RST = 2'd0,
    SRC_NMI = 2'd1,
    SRC_BRK = 2'd2,
    SRC_IRQ = 2'd3
  } int_src_e;

  localparam logic [1:0] PUSH_SEL_PCH = 2'd0;
  localparam logic [1:0] PUSH_SEL_PCL = 2'd1;
  localparam logic [1:0] PUSH_SEL_P   = 2'd2;

  localparam logic [VEC_W-1:0] NMI_VEC_DEFAULT = 16'hFFFA;
  localparam logic [VEC_W-1:0] RST_VEC_DEFAULT = 16'hFFFC;
  localparam logic [VEC_W-1:0] IRQ_VEC_DEFAULT = 16'hFFFE;

  typedef struct packed {
    logic             seq_active;
    logic             push_en;
    logic [1:0]       push_sel;
    logic             sp_dec;
    logic             b_flag;
    logic             set_i;
    logic [VEC_W-1:0] vector_addr;
    logic             pc_load_lo;
    logic             pc_load_hi;
    logic             seq_done;
  } seq_ctrl_t;

  localparam seq_ctrl_t CTRL_RESET = '{seq_active: 1'b1, default: '0};

  // BRK shares the IRQ vector.
  function automatic logic [VEC_W-1:0] vector_for(input int_src_e         src,
                                                  input logic [VEC_W-1:0] nmi_v,
                                                  input logic [VEC_W-1:0] rst_v,
                                                  input logic [VEC_W-1:0] irq_v);
    logic [VEC_W-1:0] v;
    case (src)
      SRC_NMI: v = nmi_v;
      SRC_RST: v = rst_v;
      default: v = irq_v;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/nmi_edge_detect.sv
// NMI rising-edge detector; the pending flag holds until the sequencer consumes it.
module nmi_edge_detect (
  input  logic clk_2,
  input  logic rst,
  input  logic nmi,
  input  logic clr,
  output logic pending
);

  logic sample_q, sample_d;
  logic pending_q, pending_d;

  // A fresh edge in the same cycle as a clear must not be lost.
  always_comb begin
    sample_d  = nmi;
    pending_d = (pending_q & ~clr) | (nmi & ~sample_q);
  end

  always_ff @(negedge clk_2 or posedge rst) begin
    if (rst) begin
      sample_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sample_q  <= sample_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// Owns the 7-cycle 6502 interrupt entry for RESET/NMI/BRK/IRQ and drives the
// stack, flag and PC-load micro-controls for each cycle of it.
module interrupt_sequencer
  import mos_pkg::*;
#(
  parameter logic [VEC_W-1:0] NMI_VEC = NMI_VEC_DEFAULT,
  parameter logic [VEC_W-1:0] RST_VEC = RST_VEC_DEFAULT,
  parameter logic [VEC_W-1:0] IRQ_VEC = IRQ_VEC_DEFAULT
) (
  input  logic             clk_2,
  input  logic             rst,
  input  logic             nmi,
  input  logic             irq,
  input  logic             irq_disable,
  input  logic             brk_req,
  input  logic             instr_boundary,
  output logic             seq_active,
  output logic             push_en,
  output logic [1:0]       push_sel,
  output logic             sp_dec,
  output logic             b_flag,
  output logic             set_i,
  output logic [VEC_W-1:0] vector_addr,
  output logic             pc_load_lo,
  output logic             pc_load_hi,
  output logic             seq_done
);

  seq_state_e state_q, state_d;
  int_src_e   src_q, src_d;
  int_src_e   vec_src_q, vec_src_d;
  seq_ctrl_t  ctrl_q, ctrl_d;
  logic       nmi_pending;
  logic       nmi_clr_c;

  nmi_edge_detect u_nmi_edge_detect (
    .clk_2   (clk_2),
    .rst     (rst),
    .nmi     (nmi),
    .clr     (nmi_clr_c),
    .pending (nmi_pending)
  );

  always_ff @(negedge clk_2 or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RESET_HOLD;
      src_q     <= SRC_RST;
      vec_src_q <= SRC_RST;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      vec_src_q <= vec_src_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    vec_src_d = vec_src_q;
    nmi_clr_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_boundary) begin
          if (nmi_pending) begin
            src_d   = SRC_NMI;
            state_d = ST_DUMMY1;
          end else if (brk_req) begin
            src_d   = SRC_BRK;
            state_d = ST_DUMMY1;
          end else if (irq && !irq_disable) begin
            src_d   = SRC_IRQ;
            state_d = ST_DUMMY1;
          end
        end
      end
      ST_RESET_HOLD: begin
        src_d   = SRC_RST;
        state_d = ST_DUMMY1;
      end
      ST_DUMMY1:   state_d = ST_DUMMY2;
      ST_DUMMY2:   state_d = ST_PUSH_PCH;
      ST_PUSH_PCH: state_d = ST_PUSH_PCL;
      ST_PUSH_PCL: state_d = ST_PUSH_P;
      // Vector choice freezes here; a pending NMI hijacks BRK/IRQ entries.
      ST_PUSH_P: begin
        state_d   = ST_VEC_LO;
        vec_src_d = src_q;
        if (src_q != SRC_RST) begin
          nmi_clr_c = 1'b1;
          if (nmi_pending) vec_src_d = SRC_NMI;
        end
      end
      ST_VEC_LO:   state_d = ST_VEC_HI;
      ST_VEC_HI:   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Controls are decoded from the upcoming state so they register alongside it.
  always_comb begin
    ctrl_d            = '0;
    ctrl_d.seq_active = (state_d != ST_IDLE);
    case (state_d)
      ST_PUSH_PCH: begin
        ctrl_d.push_en  = (src_d != SRC_RST);
        ctrl_d.sp_dec   = 1'b1;
        ctrl_d.push_sel = PUSH_SEL_PCH;
      end
      ST_PUSH_PCL: begin
        ctrl_d.push_en  = (src_d != SRC_RST);
        ctrl_d.sp_dec   = 1'b1;
        ctrl_d.push_sel = PUSH_SEL_PCL;
      end
      ST_PUSH_P: begin
        ctrl_d.push_en  = (src_d != SRC_RST);
        ctrl_d.sp_dec   = 1'b1;
        ctrl_d.push_sel = PUSH_SEL_P;
        ctrl_d.b_flag   = (src_d == SRC_BRK);
      end
      ST_VEC_LO: begin
        ctrl_d.vector_addr = vector_for(vec_src_d, NMI_VEC, RST_VEC, IRQ_VEC);
        ctrl_d.pc_load_lo  = 1'b1;
        ctrl_d.set_i       = 1'b1;
      end
      ST_VEC_HI: begin
        ctrl_d.vector_addr = vector_for(vec_src_d, NMI_VEC, RST_VEC, IRQ_VEC) + VEC_W'(1);
        ctrl_d.pc_load_hi  = 1'b1;
        ctrl_d.seq_done    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(negedge clk_2 or posedge rst) begin
    if (rst) ctrl_q <= CTRL_RESET;
    else     ctrl_q <= ctrl_d;
  end

  assign seq_active  = ctrl_q.seq_active;
  assign push_en     = ctrl_q.push_en;
  assign push_sel    = ctrl_q.push_sel;
  assign sp_dec      = ctrl_q.sp_dec;
  assign b_flag      = ctrl_q.b_flag;
  assign set_i       = ctrl_q.set_i;
  assign vector_addr = ctrl_q.vector_addr;
  assign pc_load_lo  = ctrl_q.pc_load_lo;
  assign pc_load_hi  = ctrl_q.pc_load_hi;
  assign seq_done    = ctrl_q.seq_done;

endmodule
